// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and EX/MEM register.
// Redirect/target are combinational; ALU result and control are registered.
package execute_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001,
        ALU_PASS = 4'b1010
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_op_e;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  reg_dst;
        logic        mem_to_reg;
        logic        reg_wr_en;
        logic        mem_wr_en;
    } ex_mem_t;

endpackage

module execute_stage
    import execute_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_pipe_PC,
    input  logic [31:0] i_pipe_Imm,
    input  logic [31:0] i_pipe_Reg1Data,
    input  logic [31:0] i_pipe_Reg2Data,
    input  logic [4:0]  i_pipe_Reg1,
    input  logic [4:0]  i_pipe_Reg2,
    input  logic [4:0]  i_pipe_RegDst,
    input  logic [2:0]  i_pipe_Funct3,
    input  logic        i_pipe_Alu1Src,
    input  logic [1:0]  i_pipe_Alu2Src,
    input  logic [3:0]  i_pipe_AluCtr,
    input  logic        i_pipe_MemToReg,
    input  logic        i_pipe_RegWrEn,
    input  logic        i_pipe_MemWrEn,
    input  logic        i_pipe_Branch,
    input  logic        i_pipe_Jump,
    input  logic        i_pipe_JumpReg,
    input  logic        i_wb_RegWrEn,
    input  logic [4:0]  i_wb_RegDst,
    input  logic [31:0] i_wb_RegWrData,
    output logic [31:0] o_pipe_AluResult,
    output logic [31:0] o_pipe_StoreData,
    output logic [4:0]  o_pipe_RegDst,
    output logic        o_pipe_MemToReg,
    output logic        o_pipe_RegWrEn,
    output logic        o_pipe_MemWrEn,
    output logic        o_pc_Redirect,
    output logic [31:0] o_pc_Target
);

    ex_mem_t ex_mem_q;
    ex_mem_t ex_mem_d;

    logic        exm_hit1;
    logic        exm_hit2;
    logic        wb_hit1;
    logic        wb_hit2;
    logic [31:0] fwd_rs1;
    logic [31:0] fwd_rs2;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic        br_cond;
    logic [31:0] pc_rel;
    logic [31:0] jalr_sum;

    // A bubble in EX/MEM or WB has its write enable low, so it never forwards.
    assign exm_hit1 = ex_mem_q.reg_wr_en && (ex_mem_q.reg_dst != 5'd0)
                   && (ex_mem_q.reg_dst == i_pipe_Reg1);
    assign exm_hit2 = ex_mem_q.reg_wr_en && (ex_mem_q.reg_dst != 5'd0)
                   && (ex_mem_q.reg_dst == i_pipe_Reg2);
    assign wb_hit1  = i_wb_RegWrEn && (i_wb_RegDst != 5'd0)
                   && (i_wb_RegDst == i_pipe_Reg1);
    assign wb_hit2  = i_wb_RegWrEn && (i_wb_RegDst != 5'd0)
                   && (i_wb_RegDst == i_pipe_Reg2);

    // rs1 forwarding mux; the younger EX/MEM result wins over WB.
    always_comb begin
        fwd_rs1 = i_pipe_Reg1Data;
        unique case (1'b1)
            exm_hit1:            fwd_rs1 = ex_mem_q.alu_result;
            wb_hit1 && !exm_hit1: fwd_rs1 = i_wb_RegWrData;
            default:             fwd_rs1 = i_pipe_Reg1Data;
        endcase
    end

    // rs2 forwarding mux; same priority as rs1.
    always_comb begin
        fwd_rs2 = i_pipe_Reg2Data;
        unique case (1'b1)
            exm_hit2:            fwd_rs2 = ex_mem_q.alu_result;
            wb_hit2 && !exm_hit2: fwd_rs2 = i_wb_RegWrData;
            default:             fwd_rs2 = i_pipe_Reg2Data;
        endcase
    end

    assign op_a = i_pipe_Alu1Src ? i_pipe_PC : fwd_rs1;

    // Operand B select: rs2, immediate, link increment or zero.
    always_comb begin
        op_b = 32'd0;
        case (i_pipe_Alu2Src)
            2'b00:   op_b = fwd_rs2;
            2'b01:   op_b = i_pipe_Imm;
            2'b10:   op_b = 32'd4;
            default: op_b = 32'd0;
        endcase
    end

    assign shamt = op_b[4:0];

    // ALU; unassigned opcodes yield zero.
    always_comb begin
        alu_res = 32'd0;
        case (alu_op_e'(i_pipe_AluCtr))
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_res = {31'd0, op_a < op_b};
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:   alu_res = op_a | op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_PASS: alu_res = op_b;
            default:  alu_res = 32'd0;
        endcase
    end

    // Branch condition on forwarded register values; 010/011 never taken.
    always_comb begin
        br_cond = 1'b0;
        case (br_op_e'(i_pipe_Funct3))
            BR_EQ:   br_cond = (fwd_rs1 == fwd_rs2);
            BR_NE:   br_cond = (fwd_rs1 != fwd_rs2);
            BR_LT:   br_cond = ($signed(fwd_rs1) < $signed(fwd_rs2));
            BR_GE:   br_cond = ($signed(fwd_rs1) >= $signed(fwd_rs2));
            BR_LTU:  br_cond = (fwd_rs1 < fwd_rs2);
            BR_GEU:  br_cond = (fwd_rs1 >= fwd_rs2);
            default: br_cond = 1'b0;
        endcase
    end

    assign pc_rel   = i_pipe_PC + i_pipe_Imm;
    assign jalr_sum = (fwd_rs1 + i_pipe_Imm) & ~32'd1;

    assign o_pc_Redirect = (i_pipe_Branch & br_cond) | i_pipe_Jump;

    // JALR target only when it actually redirects; PC+imm otherwise.
    assign o_pc_Target = (o_pc_Redirect && i_pipe_JumpReg) ? jalr_sum : pc_rel;

    // Next EX/MEM contents; redirecting instructions commit as well.
    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.alu_result = alu_res;
        ex_mem_d.store_data = fwd_rs2;
        ex_mem_d.reg_dst    = i_pipe_RegDst;
        ex_mem_d.mem_to_reg = i_pipe_MemToReg;
        ex_mem_d.reg_wr_en  = i_pipe_RegWrEn;
        ex_mem_d.mem_wr_en  = i_pipe_MemWrEn;
    end

    // EX/MEM pipeline register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign o_pipe_AluResult = ex_mem_q.alu_result;
    assign o_pipe_StoreData = ex_mem_q.store_data;
    assign o_pipe_RegDst    = ex_mem_q.reg_dst;
    assign o_pipe_MemToReg  = ex_mem_q.mem_to_reg;
    assign o_pipe_RegWrEn   = ex_mem_q.reg_wr_en;
    assign o_pipe_MemWrEn   = ex_mem_q.mem_wr_en;

endmodule

// File: tb/tb_execute_stage.sv
// Randomized and directed bench for execute_stage.
// Expected values come from an arithmetic reference model of the stage.
module tb_execute_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] r1d;
        logic [31:0] r2d;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        a1s;
        logic [1:0]  a2s;
        logic [3:0]  op;
        logic        mtr;
        logic        rwe;
        logic        mwe;
        logic        br;
        logic        j;
        logic        jr;
        logic        wbe;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
    } instr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, imm, r1d, r2d, wbd;
    logic [4:0]  r1, r2, rd, wbrd;
    logic [2:0]  f3;
    logic        a1s, mtr, rwe, mwe, br, j, jr, wbe;
    logic [1:0]  a2s;
    logic [3:0]  op;
    logic [31:0] alu_o, sd_o, tgt_o;
    logic [4:0]  rd_o;
    logic        mtr_o, rwe_o, mwe_o, redir_o;

    int n_chk  = 0;
    int n_pass = 0;

    // reference EX/MEM state
    logic [31:0] m_alu, m_sd;
    logic [4:0]  m_rd;
    logic        m_mtr, m_rwe, m_mwe;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk              (clk),
        .reset            (reset),
        .i_pipe_PC        (pc),
        .i_pipe_Imm       (imm),
        .i_pipe_Reg1Data  (r1d),
        .i_pipe_Reg2Data  (r2d),
        .i_pipe_Reg1      (r1),
        .i_pipe_Reg2      (r2),
        .i_pipe_RegDst    (rd),
        .i_pipe_Funct3    (f3),
        .i_pipe_Alu1Src   (a1s),
        .i_pipe_Alu2Src   (a2s),
        .i_pipe_AluCtr    (op),
        .i_pipe_MemToReg  (mtr),
        .i_pipe_RegWrEn   (rwe),
        .i_pipe_MemWrEn   (mwe),
        .i_pipe_Branch    (br),
        .i_pipe_Jump      (j),
        .i_pipe_JumpReg   (jr),
        .i_wb_RegWrEn     (wbe),
        .i_wb_RegDst      (wbrd),
        .i_wb_RegWrData   (wbd),
        .o_pipe_AluResult (alu_o),
        .o_pipe_StoreData (sd_o),
        .o_pipe_RegDst    (rd_o),
        .o_pipe_MemToReg  (mtr_o),
        .o_pipe_RegWrEn   (rwe_o),
        .o_pipe_MemWrEn   (mwe_o),
        .o_pc_Redirect    (redir_o),
        .o_pc_Target      (tgt_o)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_fwd(input instr_t t, input logic [4:0] a,
                                            input logic [31:0] rf);
        if (a == 0) return rf;
        if (m_rwe && m_rd == a) return m_alu;
        if (t.wbe && t.wbrd == a) return t.wbd;
        return rf;
    endfunction

    // signed compare by biasing the sign bit into unsigned space
    function automatic logic slt(input logic [31:0] a, input logic [31:0] b);
        return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ext;
        int sh;
        sh  = int'(b % 32);
        ext = {{32{a[31]}}, a};
        case (o)
            4'd0:    return a + b;
            4'd1:    return a + ~b + 32'd1;
            4'd2:    return a * (32'd1 << sh);
            4'd3:    return {31'd0, slt(a, b)};
            4'd4:    return {31'd0, a < b};
            4'd5:    return (a | b) & ~(a & b);
            4'd6:    return a / (33'd1 << sh);
            4'd7:    return ext[sh +: 32];
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_cond(input logic [2:0] f,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        case (f)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return slt(a, b);
            3'b101:  return !slt(a, b);
            3'b110:  return a < b;
            3'b111:  return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    task automatic apply(input instr_t t);
        pc = t.pc; imm = t.imm; r1d = t.r1d; r2d = t.r2d;
        r1 = t.r1; r2 = t.r2; rd = t.rd; f3 = t.f3;
        a1s = t.a1s; a2s = t.a2s; op = t.op;
        mtr = t.mtr; rwe = t.rwe; mwe = t.mwe;
        br = t.br; j = t.j; jr = t.jr;
        wbe = t.wbe; wbrd = t.wbrd; wbd = t.wbd;
    endtask

    // Called one time unit after a rising edge; leaves us at the same phase.
    task automatic run(input instr_t t);
        logic [31:0] fa, fb, a, b, res, tgt;
        logic        red;
        apply(t);
        #2;
        fa  = ref_fwd(t, t.r1, t.r1d);
        fb  = ref_fwd(t, t.r2, t.r2d);
        a   = t.a1s ? t.pc : fa;
        b   = (t.a2s == 0) ? fb : (t.a2s == 1) ? t.imm :
              (t.a2s == 2) ? 32'd4 : 32'd0;
        res = ref_alu(t.op, a, b);
        red = (t.br && ref_cond(t.f3, fa, fb)) || t.j;
        tgt = (red && t.jr) ? ((fa + t.imm) & 32'hFFFF_FFFE) : t.pc + t.imm;
        chk("redirect", {31'd0, redir_o}, {31'd0, red});
        chk("target", tgt_o, tgt);
        @(posedge clk);
        #1;
        m_alu = res; m_sd = fb; m_rd = t.rd;
        m_mtr = t.mtr; m_rwe = t.rwe; m_mwe = t.mwe;
        chk("alu", alu_o, m_alu);
        chk("store", sd_o, m_sd);
        chk("rd", {27'd0, rd_o}, {27'd0, m_rd});
        chk("ctl", {29'd0, mtr_o, rwe_o, mwe_o}, {29'd0, m_mtr, m_rwe, m_mwe});
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {alu_o, sd_o}, 32'd0);
        chk({tag, "_hi"}, alu_o | sd_o | {27'd0, rd_o}, 32'd0);
        chk({tag, "_ctl"}, {29'd0, mtr_o, rwe_o, mwe_o}, 32'd0);
    endtask

    function automatic instr_t rand_instr();
        instr_t t;
        t.pc   = $urandom & 32'hFFFF_FFFC;
        t.imm  = $urandom;
        t.r1d  = $urandom;
        t.r2d  = ($urandom_range(0, 3) == 0) ? t.r1d : $urandom;
        t.r1   = 5'($urandom_range(0, 3));
        t.r2   = 5'($urandom_range(0, 3));
        t.rd   = 5'($urandom_range(0, 3));
        t.f3   = 3'($urandom);
        t.a1s  = 1'($urandom);
        t.a2s  = 2'($urandom);
        t.op   = 4'($urandom);
        t.mtr  = 1'($urandom);
        t.rwe  = 1'($urandom);
        t.mwe  = 1'($urandom);
        t.br   = 1'($urandom);
        t.j    = ($urandom_range(0, 5) == 0);
        t.jr   = 1'($urandom);
        t.wbe  = 1'($urandom);
        t.wbrd = 5'($urandom_range(0, 3));
        t.wbd  = $urandom;
        if ($urandom_range(0, 7) == 0) begin
            t.mtr = 0; t.rwe = 0; t.mwe = 0;
            t.br = 0; t.j = 0; t.jr = 0;
        end
        return t;
    endfunction

    instr_t t;
    instr_t bub;

    initial begin
        bub = '0;
        t = rand_instr();
        t.rwe = 1; t.mwe = 1; t.mtr = 1;
        reset = 1'b1;
        apply(t);
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        m_alu = 0; m_sd = 0; m_rd = 0; m_mtr = 0; m_rwe = 0; m_mwe = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        m_alu = 0;
        // the capture just made is the first after release
        reset = 1'b1; #1; reset = 1'b0;

        // ADD rs1 + imm(-1)
        t = bub; t.r1 = 5'd10; t.r1d = 32'd5; t.imm = 32'hFFFF_FFFF;
        t.a2s = 2'b01; t.op = 4'd0; t.rd = 5'd6; t.rwe = 1;
        run(t);
        chk("add_neg", alu_o, 32'd4);

        // x3 <- 7, then read x3 with WB also writing 9
        t = bub; t.r1 = 5'd12; t.r1d = 32'd7; t.a2s = 2'b11;
        t.rd = 5'd3; t.rwe = 1;
        run(t);
        t = bub; t.r1 = 5'd3; t.r1d = 32'd1; t.a2s = 2'b11;
        t.rd = 5'd8; t.rwe = 1; t.wbe = 1; t.wbrd = 5'd3; t.wbd = 32'd9;
        run(t);
        chk("fwd_exm", alu_o, 32'd7);

        // same with x0: no forwarding
        t = bub; t.r1 = 5'd12; t.r1d = 32'd7; t.a2s = 2'b11; t.rwe = 1;
        run(t);
        t = bub; t.a2s = 2'b11; t.rd = 5'd8; t.rwe = 1;
        t.wbe = 1; t.wbd = 32'd9;
        run(t);
        chk("fwd_x0", alu_o, 32'd0);

        // BLT / BLTU
        run(bub);
        t = bub; t.r1 = 5'd10; t.r2 = 5'd11; t.r1d = 32'hFFFF_FFFF;
        t.r2d = 32'd1; t.br = 1; t.f3 = 3'b100;
        t.pc = 32'h100; t.imm = 32'hFFFF_FFF8;
        apply(t); #2;
        chk("blt_taken", {31'd0, redir_o}, 32'd1);
        chk("blt_target", tgt_o, 32'hF8);
        t.f3 = 3'b110;
        apply(t); #2;
        chk("bltu_not", {31'd0, redir_o}, 32'd0);
        @(posedge clk); #1;
        m_alu = 0; m_sd = 32'd1; m_rd = 0; m_mtr = 0; m_rwe = 0; m_mwe = 0;

        // JALR
        t = bub; t.r1 = 5'd10; t.r1d = 32'h203; t.imm = 32'h10;
        t.j = 1; t.jr = 1; t.pc = 32'h80;
        apply(t); #2;
        chk("jalr_red", {31'd0, redir_o}, 32'd1);
        chk("jalr_tgt", tgt_o, 32'h212);
        @(posedge clk); #1;
        m_alu = 32'h203; m_sd = 0;

        // JAL link value
        t = bub; t.pc = 32'h40; t.imm = 32'h20; t.a1s = 1; t.a2s = 2'b10;
        t.j = 1; t.rd = 5'd1; t.rwe = 1;
        run(t);
        chk("jal_link", alu_o, 32'h44);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            run(rand_instr());
        end

        // reset asserted between edges
        t = rand_instr(); t.rwe = 1;
        run(t);
        t = rand_instr();
        apply(t);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("mid_reset");
        @(posedge clk); #1;
        chk_zero("held_reset");
        reset = 1'b0;
        m_alu = 0; m_sd = 0; m_rd = 0; m_mtr = 0; m_rwe = 0; m_mwe = 0;
        t = bub; t.r1 = 5'd2; t.r1d = 32'h1234; t.imm = 32'h11;
        t.a2s = 2'b01; t.op = 4'd0; t.rd = 5'd9; t.rwe = 1; t.mwe = 1;
        run(t);
        chk("post_reset", alu_o, 32'h1245);
        for (int i = 0; i < 50; i++) begin
            run(rand_instr());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
